// File: rtl/wave_pkg.sv
// Shared constants and state encodings for the field-dump serial link (both directions).
package wave_pkg;
  localparam int WORD_W       = 32;
  localparam int N_WORDS      = 100;
  localparam logic [7:0] HEADER_BYTE = 8'h01;
  localparam int HEADER_LEN   = 4;
  localparam int DELAY_FRAMES = 234;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic {ASM_HUNT, ASM_DATA} asm_state_t;
endpackage

// File: rtl/uart_rx.sv
// 8N1 byte receiver: 2-flop line synchronizer, mid-bit sampling, stop-bit check.
// byte_valid fires once per byte as the stop bit is sampled; no backpressure, consumer must take every byte.
module uart_rx
  import wave_pkg::*;
#(
  parameter int DELAY_FRAMES = wave_pkg::DELAY_FRAMES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_err
);
  localparam int TW = $clog2(DELAY_FRAMES + 1);
  localparam int HALF = (DELAY_FRAMES + 1) / 2;
  localparam logic [TW-1:0] T_HALF = TW'(HALF - 1);
  localparam logic [TW-1:0] T_BIT  = TW'(DELAY_FRAMES);

  rx_state_t     state;
  logic [1:0]    sync;
  logic [TW-1:0] timer;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          rx_s;

  assign rx_s      = sync[1];
  assign byte_data = shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync       <= 2'b11;
      state      <= RX_IDLE;
      timer      <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      sync       <= {sync[0], rx};
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
      case (state)
        RX_IDLE: begin
          timer   <= '0;
          bit_cnt <= '0;
          if (!rx_s) state <= RX_START;
        end
        RX_START: begin
          // A start bit that is high again at mid-bit is treated as line noise.
          if (timer == T_HALF) begin
            timer <= '0;
            state <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RX_DATA: begin
          if (timer == T_BIT) begin
            timer   <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= RX_STOP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RX_STOP: begin
          if (timer == T_BIT) begin
            timer      <= '0;
            byte_valid <= 1'b1;
            byte_err   <= !rx_s;
            state      <= RX_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/receive_array.sv
// Frame assembler: hunts for a 4x 0x01 header, then packs little-endian bytes into indexed word strobes.
// Strobes follow the final stop-bit sample by one cycle; no backpressure, every strobe must be consumed.
module receive_array
  import wave_pkg::*;
#(
  parameter int DELAY_FRAMES = wave_pkg::DELAY_FRAMES,
  parameter int N_WORDS      = wave_pkg::N_WORDS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       uart_rx,
  output logic [WORD_W-1:0]          word_data,
  output logic [$clog2(N_WORDS)-1:0] word_index,
  output logic                       word_valid,
  output logic                       frame_done,
  output logic                       frame_error,
  output logic                       busy
);
  localparam int IW  = $clog2(N_WORDS);
  localparam int HCW = $clog2(HEADER_LEN);
  localparam logic [IW-1:0]  W_LAST   = IW'(N_WORDS - 1);
  localparam logic [HCW-1:0] HDR_LAST = HCW'(HEADER_LEN - 1);

  logic [7:0]    byte_data;
  logic          byte_valid;
  logic          byte_err;
  asm_state_t    state;
  logic [HCW-1:0] hdr_cnt;
  logic [1:0]    byte_cnt;
  logic [23:0]   acc;
  logic [IW-1:0] wcnt;

  uart_rx #(.DELAY_FRAMES(DELAY_FRAMES)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (uart_rx),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_err   (byte_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ASM_HUNT;
      hdr_cnt     <= '0;
      byte_cnt    <= '0;
      acc         <= '0;
      wcnt        <= '0;
      word_data   <= '0;
      word_index  <= '0;
      word_valid  <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
    end else begin
      word_valid  <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      if (byte_valid) begin
        case (state)
          ASM_HUNT: begin
            if (!byte_err && byte_data == HEADER_BYTE) begin
              if (hdr_cnt == HDR_LAST) begin
                state      <= ASM_DATA;
                busy       <= 1'b1;
                hdr_cnt    <= '0;
                byte_cnt   <= '0;
                wcnt       <= '0;
                word_index <= '0;
              end else begin
                hdr_cnt <= hdr_cnt + 1'b1;
              end
            end else begin
              hdr_cnt <= '0;
            end
          end
          ASM_DATA: begin
            // A framing error abandons the partial word; earlier strobes stand.
            if (byte_err) begin
              frame_error <= 1'b1;
              busy        <= 1'b0;
              byte_cnt    <= '0;
              state       <= ASM_HUNT;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
              case (byte_cnt)
                2'd0: acc[7:0]   <= byte_data;
                2'd1: acc[15:8]  <= byte_data;
                2'd2: acc[23:16] <= byte_data;
                default: begin
                  word_data  <= {byte_data, acc};
                  word_index <= wcnt;
                  word_valid <= 1'b1;
                  wcnt       <= wcnt + 1'b1;
                  if (wcnt == W_LAST) begin
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= ASM_HUNT;
                  end
                end
              endcase
            end
          end
          default: state <= ASM_HUNT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_receive_array.sv
// Directed frames over the serial line; expected word strobes are queued and checked by a monitor.
module tb_receive_array;
  localparam int DF  = 7;
  localparam int NW  = 56;
  localparam int BIT = DF + 1;
  localparam int IW  = $clog2(NW);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          uart_rx;
  logic [31:0]   word_data;
  logic [IW-1:0] word_index;
  logic          word_valid, frame_done, frame_error, busy;

  receive_array #(.DELAY_FRAMES(DF), .N_WORDS(NW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .uart_rx     (uart_rx),
    .word_data   (word_data),
    .word_index  (word_index),
    .word_valid  (word_valid),
    .frame_done  (frame_done),
    .frame_error (frame_error),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [31:0]   dat;
    logic          done;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_ferr = 0;
  int         n_bytes = 0;
  logic [7:0] last_byte = 8'h00;
  logic       last_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: byte taps, error pulses, and scoreboard pops on every word strobe.
  always @(negedge clk) begin
    if (dut.u_rx.byte_valid) begin
      n_bytes++;
      last_byte = dut.u_rx.byte_data;
      last_err  = dut.u_rx.byte_err;
    end
    if (frame_error) n_ferr++;
    if (word_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_word: got idx %0d data %h, none expected", word_index, word_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("word_index", 32'(word_index), 32'(e.idx));
        check("word_data", word_data, e.dat);
        check("frame_done", 32'(frame_done), 32'(e.done));
      end
    end else if (frame_done) begin
      check("frame_done_without_word", 32'(frame_done), 32'd0);
    end
  end

  function automatic logic [31:0] word_of(input int kind, input int i);
    case (kind)
      0:       return (i > 46 && i < 55) ? 32'h0BEBC200 : 32'(i);
      1:       return 32'h01010101 + 32'(i);
      default: return 32'hA5C30000 | 32'(i);
    endcase
  endfunction

  task automatic bit_time(input logic v);
    uart_rx = v;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop_ok);
    uart_rx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1);
  endtask

  task automatic send_header();
    for (int k = 0; k < 4; k++) send_byte(8'h01, 1'b1);
  endtask

  task automatic push_words(input int kind, input int first, input int last, input logic full);
    for (int i = first; i <= last; i++) begin
      exp_t e;
      e.idx  = IW'(i);
      e.dat  = word_of(kind, i);
      e.done = full && (i == NW - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic drain(input string name);
    repeat (20) @(posedge clk);
    #1;
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int b0, f0;
    rst_n   = 1'b0;
    uart_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_word_data", word_data, 32'd0);
    check("rst_word_index", 32'(word_index), 32'd0);
    check("rst_word_valid", 32'(word_valid), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_error", 32'(frame_error), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Lone byte while hunting: byte seen, no word.
    b0 = n_bytes;
    send_byte(8'h55, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("single_byte_count", 32'(n_bytes - b0), 32'd1);
    check("single_byte_data", 32'(last_byte), 32'h55);
    check("single_byte_err", 32'(last_err), 32'd0);
    check("single_byte_busy", 32'(busy), 32'd0);

    // Low pulse shorter than half a bit is rejected.
    b0 = n_bytes;
    uart_rx = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    uart_rx = 1'b1;
    repeat (3 * BIT) @(posedge clk);
    #1;
    check("glitch_bytes", 32'(n_bytes - b0), 32'd0);
    check("glitch_rx_idle", 32'(dut.u_rx.state), 32'd0);

    // Full frame with the 0x0BEBC200 block in the middle.
    push_words(0, 0, NW - 1, 1'b1);
    send_header();
    check("frameA_busy_after_header", 32'(busy), 32'd1);
    for (int i = 0; i < NW; i++) send_word(word_of(0, i));
    drain("frameA_drain");
    check("frameA_busy_end", 32'(busy), 32'd0);

    // Broken header run, then a payload full of 0x01 bytes.
    push_words(1, 0, NW - 1, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h07, 1'b1);
    send_header();
    for (int i = 0; i < NW; i++) send_word(word_of(1, i));
    drain("frameB_drain");
    check("frameB_busy_end", 32'(busy), 32'd0);

    // Stop bit low on payload byte 10.
    f0 = n_ferr;
    push_words(2, 0, 1, 1'b0);
    send_header();
    for (int k = 0; k < 10; k++) send_byte(word_of(2, k / 4) >> (8 * (k % 4)), 1'b1);
    send_byte(word_of(2, 2) >> 16, 1'b0);
    repeat (3 * BIT) @(posedge clk);
    #1;
    check("err_frame_error_pulses", 32'(n_ferr - f0), 32'd1);
    check("err_busy", 32'(busy), 32'd0);
    drain("err_drain");

    push_words(2, 0, NW - 1, 1'b1);
    send_header();
    for (int i = 0; i < NW; i++) send_word(word_of(2, i));
    drain("frameC_drain");

    // Reset in the middle of word 30.
    push_words(0, 0, 29, 1'b0);
    send_header();
    for (int i = 0; i < 30; i++) send_word(word_of(0, i));
    send_byte(8'h1E, 1'b1);
    send_byte(8'h00, 1'b1);
    drain("pre_reset_drain");
    fork
      send_byte(8'h00, 1'b1);
      begin
        repeat (30) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #2;
        check("midrst_word_data", word_data, 32'd0);
        check("midrst_word_index", 32'(word_index), 32'd0);
        check("midrst_word_valid", 32'(word_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
    join
    send_byte(8'h00, 1'b1);
    for (int i = 31; i < 36; i++) send_word(word_of(0, i));
    repeat (12 * BIT) @(posedge clk);
    #1;
    check("post_reset_busy", 32'(busy), 32'd0);
    check("post_reset_no_words", 32'(exp_q.size()), 32'd0);

    push_words(2, 0, 1, 1'b0);
    send_header();
    send_word(word_of(2, 0));
    send_word(word_of(2, 1));
    drain("fresh_header_drain");
    check("fresh_header_busy", 32'(busy), 32'd1);
    check("total_frame_errors", 32'(n_ferr), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/receive_array.md
# receive_array

Inbound counterpart of the field-dump serial link: receives a framed dump over UART and writes it back as a word array. A frame is a 4-byte header of 0x01 bytes followed by N_WORDS 32-bit little-endian words. The block sits between the board's `uart_rx` pin and the wave-field register array in `top`, where it loads initial conditions or replays a captured field. Its output is a word-write strobe with an index.

## Interface
- `DELAY_FRAMES`, default 234: bit period is DELAY_FRAMES+1 clocks (235 clocks at 27 MHz / 115200 baud).
- `N_WORDS`, default 100: number of 32-bit words per frame.
- `clk` input 1: system clock (27 MHz).
- `rst_n` input 1: asynchronous active-low reset.
- `uart_rx` input 1: serial line, idle high, asynchronous to `clk`.
- `word_data` output 32: assembled word, held until the next word completes.
- `word_index` output $clog2(N_WORDS): index 0..N_WORDS-1 of `word_data`.
- `word_valid` output 1: one-cycle strobe; `word_data`/`word_index` are valid this cycle.
- `frame_done` output 1: one-cycle strobe, coincident with `word_valid` for index N_WORDS-1.
- `frame_error` output 1: one-cycle strobe on a stop-bit error inside a frame.
- `busy` output 1: high from header complete until frame end or abort.

## Operation
- Reset values: `word_data`=0, `word_index`=0, `word_valid`=0, `frame_done`=0, `frame_error`=0, `busy`=0. Receiver is IDLE and the assembler is in HUNT with header count 0.
- Line input: 2-flop synchronizer with both flops reset to 1.
- Byte receiver states: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: a synchronized low starts a frame; clear the bit-timer.
  - START: at (DELAY_FRAMES+1)/2 = 117 clocks, sample the line. If high, it is a glitch: return to IDLE with no output. Otherwise go to DATA with the timer cleared.
  - DATA: sample every DELAY_FRAMES+1 clocks. LSB first, 8 bits.
  - STOP: sample one further bit period later. Pulse `byte_valid` with `byte_err` = (sample==0), then go to IDLE. A new start edge is accepted from the next cycle.
- Assembler states: HUNT, DATA.
  - HUNT: count consecutive 0x01 bytes. Any other byte or a byte error resets the count to 0. On the 4th consecutive 0x01, go to DATA, set `busy`, and clear the byte count and `word_index`.
  - DATA: byte k of a word goes into bits [8k+:8]. When the 4th byte arrives, register the word and assert `word_valid`. After the final word, assert `frame_done`, drop `busy`, and return to HUNT.
- Byte error in DATA: pulse `frame_error`, drop the partial word, clear `busy`, and return to HUNT. Words already strobed are not retracted.
- Byte error in HUNT: no `frame_error` pulse; the header count clears.
- 0x01 bytes inside the payload are data, not header.
- Reset asserted mid-byte or mid-frame returns everything to reset values immediately. The next frame needs a full header.

## Timing
- Line to synchronized line: 2 cycles.
- `byte_valid` is asserted in the cycle the stop bit is sampled. `word_valid`, `frame_done` and `frame_error` follow exactly 1 cycle later.
- Start bit to stop-bit sample: 117 + 9×235 = 2232 clocks after the synchronized falling edge.
- Minimum spacing of `word_valid` is 4 byte times, about 9400 clocks. The consumer has no backpressure and must accept every strobe.
- Back-to-back bytes with no idle time between stop bit and next start are supported. Tolerance is ±2% baud mismatch.

## Structure
- Shared package `wave_pkg` holds:
  - `WORD_W`=32;
  - `N_WORDS`=100;
  - `HEADER_BYTE`=8'h01 and `HEADER_LEN`=4;
  - `DELAY_FRAMES`=234.
- The transmit side imports the same package.
- Sub-module `uart_rx` holds the synchronizer, the byte state machine and the bit-timer. Its outputs are `byte_data[7:0]`, `byte_valid` and `byte_err`.
- `receive_array` is the header/word assembler around it.

## Test plan
- Single byte 0x55 with a valid stop bit: `uart_rx.byte_data`=0x55, `byte_valid` pulses once, `byte_err`=0. No `word_valid` is produced, because the block is still in HUNT.
- Line low pulse of 50 clocks in IDLE: no `byte_valid`, and the receiver returns to IDLE.
- Full frame, header 01 01 01 01, then word i = 0x0BEBC200 for 46<i<55, else i: 100 `word_valid` strobes with matching index/data, and `frame_done` with index 99.
- Bytes 01 01 07 01 01 01 01 then payload: sync occurs only after the last four 0x01. Word 0 is the first payload word.
- Stop bit forced low on byte 10 of the payload: words 0–1 are strobed, `frame_error` pulses once, `busy` falls, and the next clean frame is received fully.
- `rst_n` pulsed low during word 30: all outputs return to 0. Resuming the old frame's bytes yields no `word_valid` until a fresh header arrives.
